// File: rtl/dut_rr_seq_ctrl_if.sv
// Request/response bundle for dut_rr_seq_ctrl.
// slave: controller side. master: requester/consumer side.
interface dut_rr_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             rsp_ready;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/dut_rr_seq_ctrl.sv
// Round-robin sequencer for a single-bit registered serial datapath.
// Two requesters share the datapath; each granted word is cleared in,
// shifted LSB first, captured LAT cycles later and returned with its owner.
// Optional macro DUT_RR_SEQ_CTRL_CHECK_EN: compares the returned word with
// the word sent and raises a sticky err on mismatch.
module dut_rr_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  dut_rr_seq_ctrl_if.slave bus,
  output logic             dp_rst,
  output logic             dp_d_in,
  input  logic             dp_d_out,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             err
);
  localparam int CW = $clog2(WIDTH + LAT + 1);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, RESP} state_t;

  state_t           state, state_nx;
  logic             last_grant;
  logic             owner;
  logic             grant0, grant1;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] cap;
  logic [WIDTH:0]   cap_ext;
  logic [CW-1:0]    cnt;
  logic             rsp_fire;

  // new bit enters at the MSB so the first kept sample ends up in bit 0
  assign cap_ext  = {dp_d_out, cap};
  assign rsp_fire = (state == RESP) && bus.rsp_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // arbitration, next state and serial drive
  always_comb begin
    state_nx = state;
    grant0   = 1'b0;
    grant1   = 1'b0;
    dp_d_in  = 1'b0;
    case (state)
      IDLE: begin
        // gated by rst so nothing is accepted while the block is held in reset
        grant0 = !rst && bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = !rst && bus.req1_valid && (!bus.req0_valid || !last_grant);
        if (grant0 || grant1) state_nx = CLR;
      end
      CLR:   state_nx = SHIFT;
      SHIFT: begin
        dp_d_in = shreg[0];
        if (cnt == CW'(WIDTH - 1)) state_nx = DRAIN;
      end
      DRAIN: if (cnt == CW'(WIDTH + LAT - 1)) state_nx = RESP;
      RESP:  if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // grant bookkeeping, word shift-out and loopback capture
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      shreg      <= '0;
      cap        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (grant0 || grant1) begin
          last_grant <= grant1;
          owner      <= grant1;
          shreg      <= grant1 ? bus.req1_data : bus.req0_data;
        end
        CLR: cnt <= '0;
        SHIFT, DRAIN: begin
          cnt   <= cnt + CW'(1);
          shreg <= shreg >> 1;
          // first LAT samples predate the first driven bit
          if (cnt >= CW'(LAT)) cap <= cap_ext[WIDTH:1];
        end
        default: ;
      endcase
    end
  end

  // completed-transfer counter, saturating
  always_ff @(posedge clk) begin
    if (rst)                        xfer_cnt <= '0;
    else if (rsp_fire && !(&xfer_cnt)) xfer_cnt <= xfer_cnt + CNT_W'(1);
  end

`ifdef DUT_RR_SEQ_CTRL_CHECK_EN
  logic [WIDTH-1:0] sent;

  // keep an unshifted copy of the word for the loopback compare
  always_ff @(posedge clk) begin
    if (rst)                             sent <= '0;
    else if (state == IDLE && (grant0 || grant1))
      sent <= grant1 ? bus.req1_data : bus.req0_data;
  end

  // sticky mismatch flag, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst)                                err <= 1'b0;
    else if (state == RESP && cap != sent)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_data   = cap;
  assign bus.rsp_id     = owner;
  assign busy           = (state != IDLE);
  assign dp_rst         = rst || (state == CLR);
endmodule

// File: doc/dut_rr_seq_ctrl.md
Name: dut_rr_seq_ctrl

Overview:
Sequencer and arbiter for the single-bit, two-stage registered serial datapath (ports d_in, d_out, rst).
- Two word-level requesters share the datapath under round-robin arbitration.
- For each granted word, the controller clears the datapath, shifts the word in LSB first, and captures the bits returning on d_out after the fixed pipeline latency.
- It then returns the captured word to the requester with an owner tag.

Parameters:
WIDTH, 8, bits per word shifted through the datapath (1..32)
LAT, 2, datapath latency in cycles from the d_in drive cycle to the d_out sample cycle
CNT_W, 16, width of the completed-transfer counter

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 word valid
req0_data  input  WIDTH  requester 0 word
req0_ready  output  1  requester 0 accept strobe
req1_valid  input  1  requester 1 word valid
req1_data  input  WIDTH  requester 1 word
req1_ready  output  1  requester 1 accept strobe
rsp_valid  output  1  result word valid
rsp_data  output  WIDTH  captured word
rsp_id  output  1  owner of rsp_data (0/1)
rsp_ready  input  1  result consumer ready
dp_rst  output  1  datapath reset
dp_d_in  output  1  serial bit to datapath
dp_d_out  input  1  serial bit from datapath
busy  output  1  high in any state except IDLE
xfer_cnt  output  CNT_W  completed responses, saturating
err  output  1  sticky loopback mismatch flag (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high): state=IDLE; outputs req*_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, dp_d_in=0, busy=0, xfer_cnt=0, err=0; last_grant=1, so requester 0 wins the first tie.
- dp_rst = rst OR (state==CLR). The datapath is reset whenever the controller is reset.
- Reset mid-operation: the current word is abandoned, no rsp is produced, and the counter is cleared.
- Handshake: a request is accepted in the cycle reqN_valid && reqN_ready.
  - reqN_ready is a one-cycle pulse, asserted only in IDLE, and only for the granted requester.
  - The requester holds valid and data stable until accepted.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - On grant: last_grant updates and data is latched into the shift register.
- FSM:
  - IDLE: a request is granted -> CLR, with ready pulsed in the same cycle.
  - CLR (1 cycle): dp_rst=1, dp_d_in=0 -> SHIFT.
  - SHIFT (WIDTH cycles): drive dp_d_in=shreg[k] in shift cycle k, for k=0..WIDTH-1 (LSB first) -> DRAIN.
  - DRAIN (LAT cycles): dp_d_in=0 -> RESP.
  - RESP: rsp_valid=1, and rsp_data/rsp_id are held stable until rsp_ready. When rsp_valid && rsp_ready: xfer_cnt++, then -> IDLE.
- Capture rule: the bit driven in shift cycle k is sampled from dp_d_out LAT cycles later and stored at rsp_data[k]. The combined SHIFT+DRAIN window is WIDTH+LAT cycles; the first LAT samples are discarded.
- Latency: from accept to rsp_valid is 1+WIDTH+LAT+1 cycles (WIDTH=8, LAT=2: 12).
- Back-to-back throughput: one word per 12+1 cycles, because IDLE spends one cycle re-arbitrating.
- rsp_ready held low: the FSM stalls in RESP; no new request is accepted and both req*_ready stay 0.
- rsp_ready high on the first RESP cycle: completion happens in that cycle.
- xfer_cnt saturates at all-ones and does not wrap.
- New requests that arrive while busy wait. Requester priority is re-evaluated only in IDLE.

Optional Feature:
Macro DUT_RR_SEQ_CTRL_CHECK_EN.
- Defined: in RESP, compare rsp_data against the latched sent word. On mismatch, set err=1; it stays set until rst.
- Not defined: err is tied to 0 and no comparator or sent-word copy is built.

Test Plan:
- Single request: reset, then req0 with data 0xA5 -> req0_ready pulses 1 cycle, dp_rst=1 for 1 cycle, dp_d_in sequence 1,0,1,0,0,1,0,1; rsp_valid 12 cycles after accept with rsp_data=0xA5, rsp_id=0; xfer_cnt=1.
- Contention: req0=0x11 and req1=0x22 held continuously -> responses ordered id 0 (0x11), 1 (0x22), 0, 1; no requester is granted twice in a row.
- Backpressure: rsp_ready=0 for 20 cycles during RESP -> rsp_valid, rsp_data and rsp_id stay stable, req*_ready stay 0; response completes on the cycle rsp_ready rises.
- Reset mid-shift: assert rst during SHIFT cycle 4 -> next cycle every output is at its reset value and dp_rst=1; no response emitted; a following request completes normally.
- Saturation (CNT_W=4): run 17 transfers -> xfer_cnt reads 15 after the 15th completion and stays at 15.
- Check feature (macro defined): datapath model forced to invert d_out for one word of 0x3C -> rsp_data=0xC3 and err=1, remaining 1 after later clean words; with the macro undefined, err stays 0.
